// File: rtl/jtopl_eg_step_mux.sv
// ---------------------------------------------------------------------------
// jtopl_eg_step_mux
//
// Envelope-rate step engine for the JTOPL envelope generator. It serves one
// operator slot per enabled clock. It owns the global envelope counter and
// the slot sequencer. Per slot it computes the effective rate, picks a 3-bit
// window of the envelope counter and derives the step strobe. It also keeps
// each slot's previous window LSB, so sum_up needs no external feedback loop.
//
// Two-stage pipeline, both stages advance on cen:
//   stage 1 : sample the slot inputs and eg_cnt, compute rate and window
//   stage 2 : pattern lookup, per-slot LSB compare, registered outputs
//
// Parameters
//   SLOTS : operator slots per sweep (>= 2)
//   CNTW  : envelope counter width (>= 4)
//   SW    : slot index width, 2**SW >= SLOTS
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   cen        clock enable for all state
//   eg_hold    freezes the envelope counter; the sequencer keeps running
//   attack     current slot is in attack phase
//   base_rate  current slot base rate (0 = stopped)
//   keycode    current slot key code
//   ks         key scale rate enable
//   slot       slot index whose inputs are sampled this cycle
//   step       registered step strobe for slot_o
//   rate       registered effective rate for slot_o
//   sum_up     registered: window LSB changed since slot_o was last served
//   slot_o     slot index the registered outputs belong to
//   eg_cnt_o   current envelope counter
// ---------------------------------------------------------------------------
module jtopl_eg_step_mux #(
    parameter int SLOTS = 18,
    parameter int CNTW  = 15,
    parameter int SW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            eg_hold,
    input  logic            attack,
    input  logic [4:0]      base_rate,
    input  logic [3:0]      keycode,
    input  logic            ks,
    output logic [SW-1:0]   slot,
    output logic            step,
    output logic [5:0]      rate,
    output logic            sum_up,
    output logic [SW-1:0]   slot_o,
    output logic [CNTW-1:0] eg_cnt_o
);

    // Shift amount wide enough to hold CNTW-3.
    localparam int SHW = $clog2(CNTW) + 1;
    // Largest usable window offset; m itself never exceeds 16.
    localparam logic [4:0] MMAX = ((CNTW - 3) > 16) ? 5'd16 : 5'(CNTW - 3);

    // ------------------------------------------------------------------
    // Sequencer and envelope counter state
    // ------------------------------------------------------------------
    logic [SW-1:0]   slot_q;
    logic [SW-1:0]   slot_d;
    logic [CNTW-1:0] eg_cnt_q;
    logic [CNTW-1:0] eg_cnt_d;
    logic            last_slot;

    always_comb begin
        last_slot = (slot_q == SW'(SLOTS - 1));
        slot_d    = last_slot ? '0 : slot_q + SW'(1);
        // Counter moves once per sweep, after the last slot has sampled it,
        // so every slot of one sweep sees the same value.
        eg_cnt_d  = (last_slot && !eg_hold) ? eg_cnt_q + CNTW'(1) : eg_cnt_q;
    end

    // ------------------------------------------------------------------
    // Stage 1: effective rate and counter window
    // ------------------------------------------------------------------
    logic [6:0]     pre_s0;
    logic [5:0]     rate_s0;
    logic [4:0]     m_raw_s0;
    logic [4:0]     m_clip_s0;
    logic [SHW-1:0] shamt_s0;
    logic [2:0]     cnt_s0;

    always_comb begin
        // 7-bit sum; wraps for the largest base rates by design.
        if (base_rate == 5'd0) begin
            pre_s0 = 7'd0;
        end else begin
            pre_s0 = {base_rate, 2'b00} +
                     (ks ? {3'b000, keycode} : {5'b00000, keycode[3:2]});
        end
        rate_s0   = (pre_s0 >= 7'd60) ? 6'd60 : pre_s0[5:0];
        m_raw_s0  = {1'b0, rate_s0[5:2]} + {4'b0000, attack};
        m_clip_s0 = (m_raw_s0 > MMAX) ? MMAX : m_raw_s0;
        // Window eg_cnt[CNTW-1-m -: 3] is the counter shifted right by CNTW-3-m.
        shamt_s0  = SHW'(CNTW - 3) - SHW'(m_clip_s0);
        cnt_s0    = 3'(eg_cnt_q >> shamt_s0);
    end

    logic          s1_valid;
    logic [5:0]    s1_rate;
    logic [2:0]    s1_cnt;
    logic          s1_attack;
    logic [SW-1:0] s1_slot;

    // ------------------------------------------------------------------
    // Stage 2: step pattern and per-slot LSB tracking
    // ------------------------------------------------------------------
    logic [SLOTS-1:0] lsb_flag;
    logic [7:0]       pat_s1;
    logic             step_s1;
    logic             flag_cur;
    logic             sum_s1;

    always_comb begin
        pat_s1 = 8'h00;
        if (s1_rate[5:4] == 2'b11) begin
            if (s1_attack && (s1_rate[5:2] == 4'hf)) begin
                pat_s1 = 8'hff;
            end else begin
                unique case (s1_rate[1:0])
                    2'd0: pat_s1 = 8'h00;
                    2'd1: pat_s1 = 8'h88;
                    2'd2: pat_s1 = 8'haa;
                    2'd3: pat_s1 = 8'hee;
                endcase
            end
        end else begin
            if ((s1_rate[5:2] == 4'h0) && !s1_attack) begin
                pat_s1 = 8'hfe;
            end else begin
                unique case (s1_rate[1:0])
                    2'd0: pat_s1 = 8'haa;
                    2'd1: pat_s1 = 8'hea;
                    2'd2: pat_s1 = 8'hee;
                    2'd3: pat_s1 = 8'hfe;
                endcase
            end
        end
        // Rates 0 and 1 never step.
        step_s1 = (s1_rate[5:1] == 5'd0) ? 1'b0 : pat_s1[s1_cnt];
    end

    // Decoded lookup keeps out-of-range slot codes harmless.
    always_comb begin
        flag_cur = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (s1_slot == SW'(i)) begin
                flag_cur = lsb_flag[i];
            end
        end
        sum_s1 = s1_cnt[0] ^ flag_cur;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q    <= '0;
            eg_cnt_q  <= '0;
            s1_valid  <= 1'b0;
            s1_rate   <= '0;
            s1_cnt    <= '0;
            s1_attack <= 1'b0;
            s1_slot   <= '0;
            lsb_flag  <= '0;
            step      <= 1'b0;
            rate      <= '0;
            sum_up    <= 1'b0;
            slot_o    <= '0;
        end else if (cen) begin
            slot_q    <= slot_d;
            eg_cnt_q  <= eg_cnt_d;

            s1_valid  <= 1'b1;
            s1_rate   <= rate_s0;
            s1_cnt    <= cnt_s0;
            s1_attack <= attack;
            s1_slot   <= slot_q;

            if (s1_valid) begin
                step   <= step_s1;
                rate   <= s1_rate;
                sum_up <= sum_s1;
                slot_o <= s1_slot;
                for (int i = 0; i < SLOTS; i++) begin
                    if (s1_slot == SW'(i)) begin
                        lsb_flag[i] <= s1_cnt[0];
                    end
                end
            end else begin
                // Stage 1 holds nothing yet after reset.
                step   <= 1'b0;
                rate   <= '0;
                sum_up <= 1'b0;
                slot_o <= '0;
            end
        end
    end

    assign slot     = slot_q;
    assign eg_cnt_o = eg_cnt_q;

endmodule

// File: tb/tb_jtopl_eg_step_mux.sv
// Bench for jtopl_eg_step_mux: a default instance (18 slots, 15-bit counter)
// and a small one (2 slots, 4-bit counter) share the same inputs and are
// compared every cycle against a rule-level model.
module tb_jtopl_eg_step_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       eg_hold;
    logic       attack;
    logic [4:0] base_rate;
    logic [3:0] keycode;
    logic       ks;

    logic [4:0]  a_slot;
    logic        a_step;
    logic [5:0]  a_rate;
    logic        a_sum;
    logic [4:0]  a_slot_o;
    logic [14:0] a_cnt;

    logic        b_slot;
    logic        b_step;
    logic [5:0]  b_rate;
    logic        b_sum;
    logic        b_slot_o;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    jtopl_eg_step_mux dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .eg_hold   (eg_hold),
        .attack    (attack),
        .base_rate (base_rate),
        .keycode   (keycode),
        .ks        (ks),
        .slot      (a_slot),
        .step      (a_step),
        .rate      (a_rate),
        .sum_up    (a_sum),
        .slot_o    (a_slot_o),
        .eg_cnt_o  (a_cnt)
    );

    jtopl_eg_step_mux #(
        .SLOTS (2),
        .CNTW  (4),
        .SW    (1)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .eg_hold   (eg_hold),
        .attack    (attack),
        .base_rate (base_rate),
        .keycode   (keycode),
        .ks        (ks),
        .slot      (b_slot),
        .step      (b_step),
        .rate      (b_rate),
        .sum_up    (b_sum),
        .slot_o    (b_slot_o),
        .eg_cnt_o  (b_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int n_slots[2] = '{18, 2};
    int n_cntw[2]  = '{15, 4};

    int ms_slot[2];
    int ms_cnt[2];
    int mflag[2][18];
    int p_valid[2], p_step[2], p_rate[2], p_sum[2], p_slot[2];
    int e_step[2], e_rate[2], e_sum[2], e_slot[2];

    function automatic int ref_rate(input int br, input int kc, input int ksv);
        int pre;
        if (br == 0) pre = 0;
        else pre = (br * 4 + (ksv != 0 ? kc : kc / 4)) % 128;
        return (pre >= 60) ? 60 : pre % 64;
    endfunction

    function automatic int ref_win(input int rt, input int att, input int cnt, input int cntw);
        int m;
        m = rt / 4 + att;
        if (m > cntw - 3) m = cntw - 3;
        return (cnt >> (cntw - 3 - m)) % 8;
    endfunction

    function automatic int ref_step(input int rt, input int att, input int win);
        int pat;
        int sel;
        sel = rt % 4;
        if (rt < 2) return 0;
        if (rt >= 48) begin
            if (att != 0 && rt >= 60) pat = 'hff;
            else if (sel == 0) pat = 'h00;
            else if (sel == 1) pat = 'h88;
            else if (sel == 2) pat = 'haa;
            else pat = 'hee;
        end else begin
            if (rt < 4 && att == 0) pat = 'hfe;
            else if (sel == 0) pat = 'haa;
            else if (sel == 1) pat = 'hea;
            else if (sel == 2) pat = 'hee;
            else pat = 'hfe;
        end
        return (pat >> win) & 1;
    endfunction

    task automatic model_reset(input int i);
        ms_slot[i] = 0;
        ms_cnt[i]  = 0;
        p_valid[i] = 0;
        p_step[i] = 0; p_rate[i] = 0; p_sum[i] = 0; p_slot[i] = 0;
        e_step[i] = 0; e_rate[i] = 0; e_sum[i] = 0; e_slot[i] = 0;
        for (int k = 0; k < 18; k++) mflag[i][k] = 0;
    endtask

    task automatic model_edge();
        int rt, win;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                model_reset(i);
            end else if (cen) begin
                e_step[i] = p_valid[i] != 0 ? p_step[i] : 0;
                e_rate[i] = p_valid[i] != 0 ? p_rate[i] : 0;
                e_sum[i]  = p_valid[i] != 0 ? p_sum[i]  : 0;
                e_slot[i] = p_valid[i] != 0 ? p_slot[i] : 0;
                rt  = ref_rate(int'(base_rate), int'(keycode), int'(ks));
                win = ref_win(rt, int'(attack), ms_cnt[i], n_cntw[i]);
                p_rate[i]  = rt;
                p_step[i]  = ref_step(rt, int'(attack), win);
                p_sum[i]   = (win % 2) ^ mflag[i][ms_slot[i]];
                mflag[i][ms_slot[i]] = win % 2;
                p_slot[i]  = ms_slot[i];
                p_valid[i] = 1;
                if (ms_slot[i] == n_slots[i] - 1 && !eg_hold)
                    ms_cnt[i] = (ms_cnt[i] + 1) % (1 << n_cntw[i]);
                ms_slot[i] = (ms_slot[i] + 1) % n_slots[i];
            end
        end
    endtask

    task automatic check_all();
        check_eq("a_slot",   int'(a_slot),   ms_slot[0]);
        check_eq("a_cnt",    int'(a_cnt),    ms_cnt[0]);
        check_eq("a_step",   int'(a_step),   e_step[0]);
        check_eq("a_rate",   int'(a_rate),   e_rate[0]);
        check_eq("a_sum_up", int'(a_sum),    e_sum[0]);
        check_eq("a_slot_o", int'(a_slot_o), e_slot[0]);
        check_eq("b_slot",   int'(b_slot),   ms_slot[1]);
        check_eq("b_cnt",    int'(b_cnt),    ms_cnt[1]);
        check_eq("b_step",   int'(b_step),   e_step[1]);
        check_eq("b_rate",   int'(b_rate),   e_rate[1]);
        check_eq("b_sum_up", int'(b_sum),    e_sum[1]);
        check_eq("b_slot_o", int'(b_slot_o), e_slot[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input int br, input int kc, input int ksv, input int att);
        base_rate = 5'(br);
        keycode   = 4'(kc);
        ks        = 1'(ksv);
        attack    = 1'(att);
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; eg_hold = 1'b0;
        drive(0, 0, 0, 0);
        model_reset(0);
        model_reset(1);
        repeat (3) cycle();

        // Reset mid-sweep, cen ignored during reset.
        rst_n = 1'b1; cen = 1'b1;
        drive(15, 15, 1, 1);
        repeat (7) cycle();
        rst_n = 1'b0; cen = 1'b0;
        cycle();
        rst_n = 1'b1; cen = 1'b1;
        check_eq("rst_slot",   int'(a_slot),   0);
        check_eq("rst_slot_o", int'(a_slot_o), 0);
        check_eq("rst_cnt",    int'(a_cnt),    0);

        // Stopped rate.
        for (int n = 0; n < 64 * 18; n++) begin
            drive(0, 15, 1, int'($urandom_range(0, 1)));
            cycle();
        end

        // Fastest attack: step every slot every sweep.
        drive(15, 15, 1, 1);
        repeat (20 * 18) cycle();
        check_eq("fast_step", int'(a_step), 1);
        check_eq("fast_rate", int'(a_rate), 60);

        // Rate 4 decay: alternating pattern over windows.
        drive(1, 3, 0, 0);
        repeat (40 * 18) cycle();

        // Held counter: sequencer keeps wrapping.
        eg_hold = 1'b1;
        repeat (3 * 18) cycle();
        eg_hold = 1'b0;

        // Slot 0 at rate 60 decay, others at rate 4, with cen gaps.
        for (int n = 0; n < 60 * 18; n++) begin
            cen = ($urandom_range(0, 3) != 0);
            if (ms_slot[0] == 0) drive(15, 15, 1, 0);
            else drive(1, 3, 0, 0);
            cycle();
        end

        // Fully random traffic with occasional reset and hold.
        for (int n = 0; n < 2500; n++) begin
            cen     = ($urandom_range(0, 3) != 0);
            eg_hold = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            drive(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
